// File: rtl/boundary_port_scheduler_if.sv
// Bundle for boundary_port_scheduler: per-requester flit inputs, registered router-side flit, status.
// wd_abort exists only when BOUNDARY_SCHED_WATCHDOG_EN is defined.
interface boundary_port_scheduler_if #(
  parameter int N_REQ  = 2,
  parameter int FLIT_W = 64,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  // Handshake: requester i transfers a flit on a rising clk edge where in_valid[i] & in_ready[i];
  // in_ready is combinational from in_valid/in_label/out_on. out_valid is a single-cycle pulse per
  // forwarded flit with no backpressure; the router throttles with the on/off level out_on.
  logic [N_REQ-1:0]        in_valid;
  logic [2*N_REQ-1:0]      in_label;
  logic [FLIT_W*N_REQ-1:0] in_data;
  logic [N_REQ-1:0]        in_ready;
  logic                    out_on;
  logic                    out_valid;
  logic [1:0]              out_label;
  logic [FLIT_W-1:0]       out_data;
  logic [IDX_W-1:0]        owner;
  logic                    locked;
  logic                    proto_err;
  logic [0:0]              fsm_state;
`ifdef BOUNDARY_SCHED_WATCHDOG_EN
  logic                    wd_abort;

  modport master (output in_valid, in_label, in_data, out_on,
                  input  in_ready, out_valid, out_label, out_data, owner, locked, proto_err,
                         fsm_state, wd_abort);
  modport slave  (input  in_valid, in_label, in_data, out_on,
                  output in_ready, out_valid, out_label, out_data, owner, locked, proto_err,
                         fsm_state, wd_abort);
`else
  modport master (output in_valid, in_label, in_data, out_on,
                  input  in_ready, out_valid, out_label, out_data, owner, locked, proto_err,
                         fsm_state);
  modport slave  (input  in_valid, in_label, in_data, out_on,
                  output in_ready, out_valid, out_label, out_data, owner, locked, proto_err,
                         fsm_state);
`endif
endinterface

// File: rtl/boundary_port_scheduler.sv
// Wormhole round-robin scheduler sharing one router input port between N_REQ flit sources.
// Optional lock watchdog (WD_LIMIT, wd_abort) enabled by BOUNDARY_SCHED_WATCHDOG_EN.
module boundary_port_scheduler #(
  parameter int N_REQ  = 2,
  parameter int FLIT_W = 64,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
`ifdef BOUNDARY_SCHED_WATCHDOG_EN
  , parameter int WD_LIMIT = 255
`endif
) (
  input logic                     clk,
  input logic                     rst,
  boundary_port_scheduler_if.slave bus
);

  localparam logic [1:0] LBL_HEAD = 2'b00;
  localparam logic [1:0] LBL_TAIL = 2'b10;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner_q;
  logic              locked_q;
  logic              proto_err_q;
  logic              out_valid_q;
  logic [1:0]        out_label_q;
  logic [FLIT_W-1:0] out_data_q;

  logic [N_REQ-1:0]  head_req;
  logic [N_REQ-1:0]  cont_req;
  logic [N_REQ-1:0]  grant_oh;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W:0]    idx;
  logic              accept;
  logic              perr;
  logic [1:0]        sel_label;
  logic [FLIT_W-1:0] sel_data;
  logic              wd_fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // HEAD (00) and HEADTAIL (11) are the labels whose two bits are equal.
  always_comb begin
    head_req = '0;
    cont_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      head_req[i] = bus.in_valid[i] & (bus.in_label[2*i+1] == bus.in_label[2*i]);
      cont_req[i] = bus.in_valid[i] & (bus.in_label[2*i+1] != bus.in_label[2*i]);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = owner_q;
    idx   = '0;
    if (state == S_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (idx >= (IDX_W+1)'(N_REQ)) idx = idx - (IDX_W+1)'(N_REQ);
        if (!found && head_req[idx[IDX_W-1:0]]) begin
          found = 1'b1;
          win   = idx[IDX_W-1:0];
        end
      end
    end else if (cont_req[owner_q]) begin
      found = 1'b1;
      win   = owner_q;
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) grant_oh[i] = found & (win == IDX_W'(i));
  end

  assign accept    = found & bus.out_on;
  assign sel_label = bus.in_label[2*int'(win) +: 2];
  assign sel_data  = bus.in_data[FLIT_W*int'(win) +: FLIT_W];
  assign perr      = (state == S_IDLE) ? (|cont_req) : head_req[owner_q];

`ifdef BOUNDARY_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_abort_q;

  // Fires on the WD_LIMIT-th consecutive LOCKED cycle with the owner silent.
  assign wd_fire = (state == S_LOCKED) && !bus.in_valid[owner_q] &&
                   (wd_cnt == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt     <= '0;
      wd_abort_q <= 1'b0;
    end else if ((state != S_LOCKED) || bus.in_valid[owner_q]) begin
      wd_cnt <= '0;
    end else if (wd_fire) begin
      wd_cnt     <= '0;
      wd_abort_q <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus.wd_abort = wd_abort_q;
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner_q     <= '0;
      locked_q    <= 1'b0;
      proto_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_label_q <= sel_label;
        out_data_q  <= sel_data;
      end
      if (perr) proto_err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner_q <= win;
            if (sel_label == LBL_HEAD) begin
              locked_q <= 1'b1;
              state    <= S_LOCKED;
            end else begin
              rr_ptr <= next_idx(win);
            end
          end
        end
        S_LOCKED: begin
          if ((accept && sel_label == LBL_TAIL) || wd_fire) begin
            locked_q <= 1'b0;
            rr_ptr   <= next_idx(owner_q);
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = bus.out_on ? grant_oh : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_label = out_label_q;
  assign bus.out_data  = out_data_q;
  assign bus.owner     = owner_q;
  assign bus.locked    = locked_q;
  assign bus.proto_err = proto_err_q;
  assign bus.fsm_state = state;

endmodule

// File: doc/boundary_port_scheduler.md
Name: boundary_port_scheduler

Overview:
- Packet-level (wormhole) round-robin scheduler that shares one router input port between N_REQ flit sources at a chiplet boundary, e.g. the external link and internal sub-network ports.
- It locks the port to one requester from HEAD until TAIL, so packets never interleave.
- It registers the selected flit toward the router and applies on/off flow control back to the requesters.
- It sits between the boundary link adapters and the router input buffer.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- FLIT_W, 64, flit payload width in bits, excluding the label.
- IDX_W, $clog2(N_REQ) (min 1), width of the requester index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N_REQ  flit valid per requester.
- in_label  in  2*N_REQ  flit label per requester: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
- in_data  in  FLIT_W*N_REQ  flit payload per requester.
- in_ready  out  N_REQ  per-requester accept; a flit transfers when in_valid[i] & in_ready[i].
- out_on  in  1  downstream on/off; 1 means the router can accept.
- out_valid  out  1  registered flit valid to the router.
- out_label  out  2  registered label.
- out_data  out  FLIT_W  registered payload.
- owner  out  IDX_W  current or last-granted requester index.
- locked  out  1  1 while a multi-flit packet holds the port.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: out_valid=0, out_label=0, out_data=0, owner=0, locked=0, proto_err=0, rr_ptr=0, FSM=IDLE.
- Acceptance is combinational. in_ready[i]=out_on & eligible[i], and at most one bit of in_ready is set per cycle.
- Output is a 1-cycle registered stage. An accepted flit appears on out_* the next cycle with out_valid=1. With no accept, out_valid=0 next cycle, and out_label/out_data hold their last values.
- Throughput: 1 flit/cycle while out_on=1.
- Downstream must size its on/off threshold for 1 flit in flight.
- FSM IDLE:
  - eligible[i] = in_valid[i] & label in {HEAD, HEADTAIL}.
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - On accept of a HEAD: owner<=winner, locked<=1, go to LOCKED.
  - On accept of a HEADTAIL: owner<=winner, rr_ptr<=(winner+1) mod N_REQ, stay IDLE.
  - If out_on=0: no grant, rr_ptr is unchanged, no state change.
- FSM LOCKED:
  - Only the owner is eligible (in_valid[owner]); other requesters get in_ready=0.
  - Accept of BODY: stay in LOCKED.
  - Accept of TAIL: locked<=0, rr_ptr<=(owner+1) mod N_REQ, go to IDLE.
  - Owner not valid, or out_on=0: hold the lock indefinitely. There is no preemption.
- Protocol errors (set proto_err; it clears only on rst):
  - In IDLE, any in_valid[i] with label BODY or TAIL. The flit is not accepted (in_ready[i]=0) and is not forwarded.
  - In LOCKED, the owner presents HEAD or HEADTAIL. The flit is not accepted, and the state is unchanged.
- Simultaneous events:
  - A TAIL accept and new HEADs on the same cycle: the new HEADs are arbitrated in the following cycle. Minimum 1-cycle gap between packets of different requesters.
  - Same requester HEADTAIL back-to-back: the other eligible requesters win first, per round robin.
- Wrap-around: rr_ptr wraps from N_REQ-1 to 0. Indices >= N_REQ are never granted, for non-power-of-2 N_REQ.
- Reset mid-packet: the lock is dropped and out_valid goes to 0 immediately (async). The upstream is responsible for resending the packet.

Optional Feature:
- Macro BOUNDARY_SCHED_WATCHDOG_EN.
- When defined:
  - Add parameter WD_LIMIT (default 255).
  - Add a counter of consecutive LOCKED cycles in which in_valid[owner]=0.
  - The counter resets on any owner accept or on leaving LOCKED.
  - When the counter reaches WD_LIMIT: force IDLE, locked<=0, rr_ptr<=owner+1, and assert output wd_abort (1 bit, sticky until rst).
- When not defined: no counter and no wd_abort port; a lock holds indefinitely.

Test Plan:
- Reset, then req0 HEADTAIL and req1 HEADTAIL both valid, out_on=1, rr_ptr=0:
  - cycle 1: req0 accepted; out_valid=1 with req0 data at cycle 2.
  - req1 accepted at cycle 2.
  - rr_ptr=0 after both.
- req0 sends HEAD, BODY, BODY, TAIL while req1 holds HEAD from cycle 0:
  - out carries the 4 req0 flits contiguously, locked=1 through the TAIL accept.
  - req1 HEAD accepted 1 cycle after the TAIL.
- Mid-packet out_on=0 for 3 cycles:
  - in_ready=0 and out_valid=0 during those cycles; the lock holds.
  - The transfer resumes with the next BODY, with no flit loss or duplication.
- IDLE with req1 presenting BODY: in_ready[1]=0, proto_err=1 the next cycle, out_valid stays 0.
- N_REQ=3, all requesters send HEADTAIL continuously: grant order is 0,1,2,0,1,2; wrap verified.
- With BOUNDARY_SCHED_WATCHDOG_EN and WD_LIMIT=4, req0 HEAD then silence:
  - wd_abort=1 and locked=0 after 4 idle cycles.
  - req1 HEAD accepted next.
